// File: rtl/ped_request_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_unit_pkg
// Description : Shared FSM state encoding and default timing constants for
//               the pedestrian request unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ped_request_unit_pkg;

  // Controller phases; the encoding is fixed so the state register is 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK_A = 2'd1,
    ST_WALK_B = 2'd2,
    ST_CLEAR  = 2'd3
  } ped_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WALK_CYCLES     = 8;
  localparam int DEF_CLEAR_CYCLES    = 2;

  // Width of the walk/clear phase counter and of the walk_cnt output.
  localparam int PHASE_CNT_W = 4;

endpackage : ped_request_unit_pkg
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ped_debounce
// Description : Two-flop synchroniser followed by a debouncer for one raw
//               push-button. The clean level follows the synchronised level
//               only after it has been stable at the new value for
//               DEBOUNCE_CYCLES consecutive cycles; any return to the old
//               level restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_debounce
  import ped_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic clean_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Synchronise the button, then count consecutive cycles at the opposite level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        clean_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign clean_o = clean_q;

endmodule : ped_debounce
`default_nettype wire

// File: rtl/ped_request_unit.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_unit
// Description : Pedestrian request unit for a two-approach crossing. Debounces
//               two push-buttons, latches requests, forwards them to the
//               traffic-light controller while idle, and runs a timed walk
//               phase followed by a don't-walk guard when the matching amber
//               lamp is seen. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request_unit
  import ped_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int CLEAR_CYCLES    = DEF_CLEAR_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       Ra,
  input  logic       Ga,
  input  logic       Ya,
  input  logic       Rb,
  input  logic       Gb,
  input  logic       Yb,
  output logic       Sa,
  output logic       Sb,
  output logic       walk_a,
  output logic       walk_b,
  output logic       wait_a,
  output logic       wait_b,
  output logic [3:0] walk_cnt
);

  localparam logic [PHASE_CNT_W-1:0] C_WALK_LOAD  = PHASE_CNT_W'(WALK_CYCLES);
  localparam logic [PHASE_CNT_W-1:0] C_CLEAR_LOAD = PHASE_CNT_W'(CLEAR_CYCLES);

  // Only the amber lamps matter; red and green are part of the interface.
  logic unused_lamps;
  assign unused_lamps = ^{Ra, Ga, Rb, Gb};

  logic clean_a;
  logic clean_b;

  ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_a),
    .clean_o (clean_a)
  );

  ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_b),
    .clean_o (clean_b)
  );

  ped_state_t             state_q, state_d;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pend_a_q, pend_a_d;
  logic                   pend_b_q, pend_b_d;
  logic                   clean_prev_a_q, clean_prev_b_q;
  logic                   sa_q, sb_q, walk_a_q, walk_b_q;
  logic [3:0]             walk_cnt_q;
  logic                   rise_a, rise_b;
  logic                   serve_a, serve_b;

  // A press is the rising edge of the clean level; holding does not repeat it.
  assign rise_a = clean_a & ~clean_prev_a_q;
  assign rise_b = clean_b & ~clean_prev_b_q;

  // Next state, phase counter and request latches. A wins a simultaneous amber.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    serve_a = 1'b0;
    serve_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_a_q && Ya) begin
          serve_a = 1'b1;
          state_d = ST_WALK_A;
          cnt_d   = C_WALK_LOAD;
        end else if (pend_b_q && Yb) begin
          serve_b = 1'b1;
          state_d = ST_WALK_B;
          cnt_d   = C_WALK_LOAD;
        end
      end
      ST_WALK_A, ST_WALK_B: begin
        if (cnt_q <= PHASE_CNT_W'(1)) begin
          state_d = ST_CLEAR;
          cnt_d   = C_CLEAR_LOAD;
        end else begin
          cnt_d = cnt_q - PHASE_CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        if (cnt_q <= PHASE_CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - PHASE_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A press in the serving cycle survives so it is forwarded afterwards.
    pend_a_d = (pend_a_q & ~serve_a) | rise_a;
    pend_b_d = (pend_b_q & ~serve_b) | rise_b;
  end

  // FSM state, requests and all outputs registered from the next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pend_a_q       <= 1'b0;
      pend_b_q       <= 1'b0;
      clean_prev_a_q <= 1'b0;
      clean_prev_b_q <= 1'b0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      walk_a_q       <= 1'b0;
      walk_b_q       <= 1'b0;
      walk_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_a_q       <= pend_a_d;
      pend_b_q       <= pend_b_d;
      clean_prev_a_q <= clean_a;
      clean_prev_b_q <= clean_b;
      sa_q           <= (state_d == ST_IDLE) & pend_a_d;
      sb_q           <= (state_d == ST_IDLE) & pend_b_d;
      walk_a_q       <= (state_d == ST_WALK_A);
      walk_b_q       <= (state_d == ST_WALK_B);
      walk_cnt_q     <= ((state_d == ST_WALK_A) || (state_d == ST_WALK_B)) ? cnt_d : '0;
    end
  end

  assign Sa       = sa_q;
  assign Sb       = sb_q;
  assign walk_a   = walk_a_q;
  assign walk_b   = walk_b_q;
  assign wait_a   = pend_a_q;
  assign wait_b   = pend_b_q;
  assign walk_cnt = walk_cnt_q;

endmodule : ped_request_unit
`default_nettype wire

// File: tb/tb_ped_request_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_request_unit
// Description : Scoreboard bench for ped_request_unit. Stimulus is driven on
//               the falling edge; a reference model predicts the outputs after
//               the following rising edge and queues them; a monitor compares
//               the DUT shortly after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_request_unit;

  localparam int D = 4;
  localparam int W = 8;
  localparam int C = 2;

  typedef struct {
    bit       sa, sb, wa, wb, ta, tb;
    bit [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b0, btn_b = 1'b0;
  logic Ra = 1'b0, Ga = 1'b0, Ya = 1'b0, Rb = 1'b0, Gb = 1'b0, Yb = 1'b0;
  logic Sa, Sb, walk_a, walk_b, wait_a, wait_b;
  logic [3:0] walk_cnt;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model: raw button history, clean levels, requests, service timer.
  int hist_a[$];
  int hist_b[$];
  bit m_clean_a, m_clean_b, m_prev_a, m_prev_b, m_pend_a, m_pend_b;
  int m_busy;      // 0 idle, 1 serving A, 2 serving B
  int m_el;        // cycles elapsed since service began
  int last_cnt;

  ped_request_unit #(
    .DEBOUNCE_CYCLES(D),
    .WALK_CYCLES    (W),
    .CLEAR_CYCLES   (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_a    (btn_a),
    .btn_b    (btn_b),
    .Ra       (Ra),
    .Ga       (Ga),
    .Ya       (Ya),
    .Rb       (Rb),
    .Gb       (Gb),
    .Yb       (Yb),
    .Sa       (Sa),
    .Sb       (Sb),
    .walk_a   (walk_a),
    .walk_b   (walk_b),
    .wait_a   (wait_a),
    .wait_b   (wait_b),
    .walk_cnt (walk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  function automatic bit hget(input int h[$], input int back);
    int idx;
    idx = h.size() - back;
    if (idx < 0) return 1'b0;
    return h[idx] != 0;
  endfunction

  // The synchronised level seen at an edge is the button two edges earlier;
  // the clean level moves once the last D of those all agree on a new value.
  function automatic bit deb(input int h[$], input bit c);
    bit v;
    v = hget(h, 2);
    if (v == c) return c;
    for (int j = 0; j < D; j++)
      if (hget(h, 2 + j) != v) return c;
    return v;
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    m_clean_a = 0; m_clean_b = 0; m_prev_a = 0; m_prev_b = 0;
    m_pend_a  = 0; m_pend_b  = 0; m_busy   = 0; m_el     = 0;
  endtask

  task automatic model_edge(input bit r, input bit ba, input bit bb,
                            input bit ya, input bit yb);
    exp_t e;
    bit rise_a, rise_b, serve_a, serve_b, wk;
    if (r) begin
      model_reset();
    end else begin
      rise_a = m_clean_a & ~m_prev_a;
      rise_b = m_clean_b & ~m_prev_b;
      serve_a = 0;
      serve_b = 0;
      if (m_busy == 0) begin
        if (m_pend_a && ya)      serve_a = 1;
        else if (m_pend_b && yb) serve_b = 1;
      end else begin
        m_el++;
        if (m_el == W + C) m_busy = 0;
      end
      if (serve_a) begin m_busy = 1; m_el = 0; end
      if (serve_b) begin m_busy = 2; m_el = 0; end
      m_pend_a = (m_pend_a & ~serve_a) | rise_a;
      m_pend_b = (m_pend_b & ~serve_b) | rise_b;
      m_prev_a  = m_clean_a;
      m_prev_b  = m_clean_b;
      m_clean_a = deb(hist_a, m_clean_a);
      m_clean_b = deb(hist_b, m_clean_b);
      hist_a.push_back(int'(ba));
      hist_b.push_back(int'(bb));
      if (hist_a.size() > 16) void'(hist_a.pop_front());
      if (hist_b.size() > 16) void'(hist_b.pop_front());
    end
    wk    = (m_busy != 0) && (m_el < W);
    e.sa  = (m_busy == 0) && m_pend_a;
    e.sb  = (m_busy == 0) && m_pend_b;
    e.wa  = (m_busy == 1) && wk;
    e.wb  = (m_busy == 2) && wk;
    e.ta  = m_pend_a;
    e.tb  = m_pend_b;
    e.cnt = wk ? 4'(W - m_el) : 4'd0;
    last_cnt = int'(e.cnt);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge and queue the prediction.
  task automatic step(input bit r, input bit ba, input bit bb,
                      input bit ya, input bit yb);
    @(negedge clk);
    rst   = r;
    btn_a = ba;
    btn_b = bb;
    Ya    = ya;
    Yb    = yb;
    Ra    = 1'($urandom_range(0, 1));
    Ga    = 1'($urandom_range(0, 1));
    Rb    = 1'($urandom_range(0, 1));
    Gb    = 1'($urandom_range(0, 1));
    model_edge(r, ba, bb, ya, yb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges must clear every output straight away.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_Sa", int'(Sa), 0);
    chk("rst_Sb", int'(Sb), 0);
    chk("rst_walk_a", int'(walk_a), 0);
    chk("rst_walk_b", int'(walk_b), 0);
    chk("rst_wait_a", int'(wait_a), 0);
    chk("rst_wait_b", int'(wait_b), 0);
    chk("rst_walk_cnt", int'(walk_cnt), 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  // Monitor: every rising edge presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst == 1'b0 || exp_q.size() > 0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("Sa", int'(Sa), int'(e.sa));
          chk("Sb", int'(Sb), int'(e.sb));
          chk("walk_a", int'(walk_a), int'(e.wa));
          chk("walk_b", int'(walk_b), int'(e.wb));
          chk("wait_a", int'(wait_a), int'(e.ta));
          chk("wait_b", int'(wait_b), int'(e.tb));
          chk("walk_cnt", int'(walk_cnt), int'(e.cnt));
          chk("walk_exclusive", int'(walk_a & walk_b), 0);
        end
      end
    end
  end

  initial begin
    int hold_a, hold_b;
    bit lvl_a, lvl_b, ya, yb;
    model_reset();
    last_cnt = 0;
    hold_a = 0; hold_b = 0; lvl_a = 0; lvl_b = 0;

    // Power-on reset, then release.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Long press on A with no amber: request raised and held.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    idle(6);

    // Bouncing B (3 high, 1 low): must never be accepted.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    idle(4);

    // Serve A with a single amber cycle, run walk and clear.
    step(0, 0, 0, 1, 0);
    idle(14);

    // Both pending, both ambers together: A first, then B.
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 1);
    idle(13);
    step(0, 0, 0, 0, 1);
    idle(13);

    // B pressed during a walk of A.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    idle(10);
    step(0, 0, 0, 0, 1);
    idle(13);

    // Reset in the middle of a walk.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 20 && last_cnt != 5; i++) step(0, 0, 0, 0, 0);
    do_reset();
    idle(10);
    step(0, 0, 0, 1, 1);
    idle(4);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if (hold_a == 0) begin lvl_a = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 9); end
      if (hold_b == 0) begin lvl_b = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 9); end
      hold_a--;
      hold_b--;
      ya = ($urandom_range(0, 5) == 0);
      yb = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(0, lvl_a, lvl_b, ya, yb);
    end
    idle(3);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ped_request_unit
`default_nettype wire
